// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; byte-serial access to the shared 8-bit RAM port, stores absorbed by a FIFO store buffer.
// Latency: stores accepted in the cycle seen; an N-byte load returns N+1 cycles after it is seen (gnt held, buffer empty).
// Backpressure: stall while the buffer is full (stores) or until the load result is ready; ram_gnt=0 pauses RAM traffic.
module mem_lsu #(
    parameter int ADDR_W   = 32,
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    input  logic              ram_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              sb_empty
);

    localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, DRAIN, LOAD, LTAIL, LDONE} state_t;

    // last = byte count minus one (0, 1 or 3)
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
        logic [1:0]        last;
    } sb_ent_t;

    state_t            state;
    sb_ent_t           sb_mem [SB_DEPTH];
    sb_ent_t           head;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     sb_cnt, cnt_nxt;
    logic [1:0]        idx, op_last, iss_idx, cap_idx;
    logic              is_load, is_store, sb_full, push;
    logic              dr_wr, dr_pop, ld_go, ld_iss, cap_vld;
    logic [XLEN-1:0]   ld_data, ext;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dout_q;

    // Decode the request opcode into direction and size; unknown codes behave as NOP
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        op_last  = 2'd0;
        case (req_op)
            4'd1, 4'd4: is_load = 1'b1;
            4'd2, 4'd5: begin is_load = 1'b1; op_last = 2'd1; end
            4'd3:       begin is_load = 1'b1; op_last = 2'd3; end
            4'd6:       is_store = 1'b1;
            4'd7:       begin is_store = 1'b1; op_last = 2'd1; end
            4'd8:       begin is_store = 1'b1; op_last = 2'd3; end
            default:    ;
        endcase
    end

    // Sign/zero extension of the assembled load bytes
    always_comb begin
        ext = ld_data;
        case (req_op)
            4'd1:    ext = {{(XLEN-8){ld_data[7]}}, ld_data[7:0]};
            4'd2:    ext = {{(XLEN-16){ld_data[15]}}, ld_data[15:0]};
            4'd4:    ext = {{(XLEN-8){1'b0}}, ld_data[7:0]};
            4'd5:    ext = {{(XLEN-16){1'b0}}, ld_data[15:0]};
            default: ext = ld_data;
        endcase
    end

    // RAM port drive: drain writes take the port in DRAIN, loads issue from IDLE/LOAD; otherwise hold last values.
    // The first load byte is issued from IDLE so that the result lands exactly N+1 cycles after the request.
    always_comb begin
        head     = sb_mem[rd_ptr];
        sb_full  = (sb_cnt == CW'(SB_DEPTH));
        push     = is_store && !sb_full;
        dr_wr    = (state == DRAIN) && ram_gnt;
        dr_pop   = dr_wr && (idx == head.last);
        ld_go    = !rst && (state == IDLE) && is_load && (sb_cnt == '0) && ram_gnt;
        ld_iss   = ld_go || ((state == LOAD) && ram_gnt);
        iss_idx  = ld_go ? 2'd0 : idx;
        cnt_nxt  = sb_cnt + CW'(push) - CW'(dr_pop);
        ram_wr   = dr_wr;
        ram_addr = addr_q;
        ram_dout = dout_q;
        if (dr_wr) begin
            ram_addr = head.addr + ADDR_W'(idx);
            ram_dout = head.data[{idx, 3'b000} +: 8];
        end else if (ld_iss) begin
            ram_addr = req_addr + ADDR_W'(iss_idx);
        end
    end

    assign stall    = is_store ? sb_full : (is_load && (state != LDONE));
    assign wb_valid = (state == LDONE);
    assign wb_rd    = wb_valid ? req_rd : 5'd0;
    assign wb_data  = wb_valid ? ext : '0;

    // Control FSM: drain one buffered entry per visit to DRAIN, or walk the bytes of a load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if ((sb_cnt != '0) && ram_gnt) begin
                        state <= DRAIN;
                        idx   <= 2'd0;
                    end else if (ld_go) begin
                        idx   <= 2'd1;
                        state <= (op_last == 2'd0) ? LTAIL : LOAD;
                    end
                end
                DRAIN: begin
                    if (dr_pop) begin
                        state <= IDLE;
                        idx   <= 2'd0;
                    end else if (dr_wr) begin
                        idx <= idx + 2'd1;
                    end
                end
                LOAD: begin
                    if (ram_gnt) begin
                        if (idx == op_last) state <= LTAIL;
                        else                idx   <= idx + 2'd1;
                    end
                end
                LTAIL:   state <= LDONE;
                LDONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture each load byte the cycle after its address was issued; remember last RAM address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld <= 1'b0;
            cap_idx <= 2'd0;
            ld_data <= '0;
            addr_q  <= '0;
            dout_q  <= 8'd0;
        end else begin
            cap_vld <= ld_iss;
            cap_idx <= iss_idx;
            if (cap_vld) ld_data[{cap_idx, 3'b000} +: 8] <= ram_din;
            if (dr_wr || ld_iss) addr_q <= ram_addr;
            if (dr_wr) dout_q <= ram_dout;
        end
    end

    // Store-buffer pointers and occupancy; a full buffer refuses even when an entry retires this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sb_cnt   <= '0;
            sb_empty <= 1'b1;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (dr_pop) rd_ptr <= rd_ptr + PW'(1);
            sb_cnt   <= cnt_nxt;
            sb_empty <= (cnt_nxt == '0);
        end
    end

    // Store-buffer storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (push) sb_mem[wr_ptr] <= '{addr: req_addr, data: req_wdata, last: op_last};
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                           LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ram_gnt;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        sb_empty;

    logic        gnt_lvl = 1'b0;
    logic        gnt_tgl_en = 1'b0;
    logic        tgl = 1'b0;

    int          vecs = 0;
    int          errs = 0;
    int          wr_seen = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [39:0] wexp [$];   // {addr, byte} in expected write order
    logic [36:0] ldexp [$];  // {rd, data}

    mem_lsu #(.ADDR_W(32), .XLEN(32), .SB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout),
        .ram_din(ram_din), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tgl <= ~tgl;
    assign ram_gnt = gnt_tgl_en ? tgl : gnt_lvl;

    // Synchronous RAM: read data appears the cycle after the address is presented
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] = ram_dout;
        else if (ram_gnt) ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every RAM write must match the next expected store byte, in order, under grant
    always @(negedge clk) begin
        logic [39:0] e;
        if (ram_wr === 1'b1) begin
            wr_seen++;
            e = 40'hx;
            if (wexp.size() != 0) e = wexp.pop_front();
            chk("ram_write", {24'd0, ram_addr, ram_dout}, {24'd0, e});
            chk("wr_gnt", ram_gnt, 1);
        end
    end

    task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] exp, input int exp_st, input string tag);
        int st;
        int bound;
        logic [36:0] e;
        st = 0;
        bound = 0;
        ldexp.push_back({rd, exp});
        req_op = op; req_addr = addr; req_rd = rd; req_wdata = $urandom;
        @(negedge clk);
        while (!wb_valid && bound < 200) begin
            if (stall === 1'b1) st++;
            bound++;
            @(negedge clk);
        end
        chk({tag, "_vld"}, wb_valid, 1);
        if (wb_valid === 1'b1) begin
            e = ldexp.pop_front();
            chk({tag, "_data"}, wb_data, e[31:0]);
            chk({tag, "_rd"}, wb_rd, e[36:32]);
            chk({tag, "_stall0"}, stall, 0);
        end
        if (exp_st >= 0) chk({tag, "_stalls"}, st, exp_st);
        @(posedge clk); #1;
        req_op = NOP;
    endtask

    task automatic do_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_stall, input string tag);
        int n;
        logic [31:0] a;
        n = (op == SB) ? 1 : (op == SH) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            wexp.push_back({a, data[8*k +: 8]});
        end
        req_op = op; req_addr = addr; req_wdata = data; req_rd = 5'd0;
        @(negedge clk);
        chk({tag, "_stall"}, stall, exp_stall);
        @(posedge clk); #1;
    endtask

    initial begin
        int b;
        int w0;
        rst = 1'b1; req_op = NOP; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
        ram[32'h7] = 8'h80; ram[32'h3] = 8'h81; ram[32'h4] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_dout", ram_dout, 0);
        chk("rst_wb_valid", wb_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("nop_stall", stall, 0);
        @(posedge clk); #1;

        // Loads with grant held
        gnt_lvl = 1'b1;
        do_load(LW,  32'h100, 5'd3,  32'h12345678, 5, "lw");
        do_load(LB,  32'h7,   5'd4,  32'hFFFFFF80, 2, "lb");
        do_load(LBU, 32'h7,   5'd5,  32'h00000080, 2, "lbu");
        do_load(LH,  32'h3,   5'd6,  32'hFFFFFF81, 3, "lh_unal");

        // Grant toggling every cycle doubles the issue phase
        do begin @(posedge clk); #1; end while (tgl !== 1'b1);
        gnt_tgl_en = 1'b1;
        do_load(LW, 32'h100, 5'd7, 32'h12345678, 8, "lw_tgl");
        gnt_tgl_en = 1'b0;

        // Fill the store buffer with no grant, then let it drain
        gnt_lvl = 1'b0;
        for (int i = 0; i < 4; i++) do_store(SW, 32'h400 + 4*i, 32'hA0B0C0D0 + i, 1'b0, "sw_fill");
        do_store(SW, 32'h410, 32'h0F1E2D3C, 1'b1, "sw_full");
        chk("sb_nonempty", sb_empty, 0);
        gnt_lvl = 1'b1;
        w0 = wr_seen;
        b = 0;
        @(negedge clk);
        while (stall === 1'b1 && b < 50) begin b++; @(negedge clk); end
        chk("sw5_accept", stall, 0);
        chk("sw5_writes_before", wr_seen - w0, 4);
        @(posedge clk); #1;
        req_op = 4'hF;
        @(negedge clk);
        chk("bad_op_stall", stall, 0);
        chk("bad_op_wbv", wb_valid, 0);
        @(posedge clk); #1;
        req_op = NOP;
        b = 0;
        while (sb_empty !== 1'b1 && b < 100) begin b++; @(posedge clk); #1; end
        chk("drain_done", sb_empty, 1);
        chk("drain_all_bytes", wexp.size(), 0);
        chk("ram_40c", ram[32'h40C], 8'hD3);
        chk("ram_413", ram[32'h413], 8'h0F);

        // Load ordered behind a buffered store
        do_store(SH, 32'h200, 32'hDEADBEEF, 1'b0, "sh");
        do_load(LHU, 32'h200, 5'd9, 32'h0000BEEF, -1, "lhu_after_sh");

        // Address wrap inside one access, store then load
        do_store(SW, 32'hFFFFFFFF, 32'h44332211, 1'b0, "sw_wrap");
        do_load(LW, 32'hFFFFFFFF, 5'd10, 32'h44332211, -1, "lw_wrap");
        chk("ram_wrap0", ram[32'h0], 8'h22);

        // Reset in the middle of a load
        req_op = LW; req_addr = 32'h100; req_rd = 5'd11;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rst_ld_wbv", wb_valid, 0);
        chk("rst_ld_wr", ram_wr, 0);
        chk("rst_ld_addr", ram_addr, 0);
        req_op = NOP;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the middle of a drain
        gnt_lvl = 1'b0;
        do_store(SW, 32'h300, 32'h01020304, 1'b0, "sw_a");
        do_store(SW, 32'h304, 32'h05060708, 1'b0, "sw_b");
        req_op = NOP;
        gnt_lvl = 1'b1;
        w0 = wr_seen;
        b = 0;
        while (wr_seen == w0 && b < 20) begin b++; @(posedge clk); #1; end
        chk("drain_started", wr_seen - w0, 1);
        rst = 1'b1;
        wexp.delete();
        #1;
        chk("rst_dr_empty", sb_empty, 1);
        chk("rst_dr_wr", ram_wr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        w0 = wr_seen;
        repeat (10) begin @(posedge clk); #1; end
        chk("rst_no_writes", wr_seen - w0, 0);
        chk("rst_still_empty", sb_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
